// File: rtl/pulse_stretch_out.sv
// pulse_stretch_out: turns single-cycle trig ticks into ON_CYCLES-long pulses separated by GAP_CYCLES gaps, queuing extra triggers.
// Define PULSE_STRETCH_RETRIG_EN to make a trig during a pulse restart its ON time instead of queuing.
module pulse_stretch_out #(
  parameter int N          = 22,
  parameter int ON_CYCLES  = 2500000,
  parameter int GAP_CYCLES = 1250000,
  parameter int PEND_W     = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              trig,
  output logic              pulse_out,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              ovf_tick
);
  typedef enum logic [1:0] {IDLE = 2'd0, ON = 2'd1, GAP = 2'd2} state_t;
  localparam logic [N-1:0]      ON_LAST  = N'(ON_CYCLES - 1);
  localparam logic [N-1:0]      GAP_LAST = N'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  state_t            state, state_n;
  logic [N-1:0]      timer, timer_n;
  logic [PEND_W-1:0] pend_n;
  logic              ovf_n, inc, dec, has_pend;
  assign has_pend = pend_cnt != '0;
  always_comb begin
    state_n = state;
    timer_n = timer + 1'b1;
    inc     = 1'b0;
    dec     = 1'b0;
    case (state)
      IDLE: begin
        timer_n = '0;
        state_n = trig ? ON : IDLE;
      end
      ON: begin
        if (timer == ON_LAST) begin
          state_n = GAP;
          timer_n = '0;
        end
`ifdef PULSE_STRETCH_RETRIG_EN
        if (trig) begin
          state_n = ON;
          timer_n = '0;
        end
`else
        inc = trig;
`endif
      end
      GAP: begin
        if (timer == GAP_LAST) begin
          timer_n = '0;
          state_n = (has_pend || trig) ? ON : IDLE;
          dec     = has_pend;
          inc     = trig && has_pend;
        end else begin
          inc = trig;
        end
      end
      default: begin
        state_n = IDLE;
        timer_n = '0;
      end
    endcase
    // a simultaneous consume and enqueue leaves the count unchanged
    ovf_n  = inc && !dec && pend_cnt == PEND_MAX;
    pend_n = (inc && !dec && !ovf_n) ? pend_cnt + 1'b1 :
             (dec && !inc)           ? pend_cnt - 1'b1 : pend_cnt;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      timer     <= '0;
      pend_cnt  <= '0;
      pulse_out <= 1'b0;
      busy      <= 1'b0;
      ovf_tick  <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      pend_cnt  <= pend_n;
      pulse_out <= state_n == ON;
      busy      <= state_n != IDLE;
      ovf_tick  <= ovf_n;
    end
  end
endmodule

// File: tb/tb_pulse_stretch_out.sv
// tb_pulse_stretch_out: random triggers against a timeline model of pulse start times, checked through a scoreboard queue.
module tb_pulse_stretch_out;
  localparam int N = 4, ON = 4, GAP = 2, PW = 2, PMAX = (1 << PW) - 1;
`ifdef PULSE_STRETCH_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif
  typedef struct packed {
    logic          p;
    logic          b;
    logic [PW-1:0] c;
    logic          o;
  } exp_t;
  logic          clk = 1'b0, rst_n = 1'b0, trig = 1'b0;
  logic          pulse_out, busy, ovf_tick;
  logic [PW-1:0] pend_cnt;
  exp_t          q[$];
  int            passed = 0, total = 0, cyc = 0, start = -1000, pend = 0;
  bit            ovf = 1'b0;
  always #5 clk = ~clk;
  pulse_stretch_out #(.N(N), .ON_CYCLES(ON), .GAP_CYCLES(GAP), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .trig(trig), .pulse_out(pulse_out),
    .busy(busy), .pend_cnt(pend_cnt), .ovf_tick(ovf_tick)
  );
  task automatic chk(input string name, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s at cycle %0d: got %0d expected %0d", name, cyc, got, exp);
  endtask
  function automatic exp_t expect_now();
    exp_t x;
    int   e = cyc - start;
    x.p = e >= 0 && e < ON;
    x.b = e >= 0 && e < ON + GAP;
    x.c = PW'(pend);
    x.o = ovf;
    return x;
  endfunction
  // elapsed time since the current pulse began decides the phase
  task automatic step(input bit t);
    int e = cyc - start;
    trig = t;
    ovf  = 1'b0;
    if (e >= ON + GAP) begin
      if (t) start = cyc + 1;
    end else if (e == ON + GAP - 1 && (pend > 0 || t)) begin
      start = cyc + 1;
      if (pend > 0 && !t) pend--;
    end else if (RETRIG && e < ON && t) begin
      start = cyc + 1;
    end else if (t) begin
      if (pend == PMAX) ovf = 1'b1;
      else pend++;
    end
    cyc++;
    q.push_back(expect_now());
    @(posedge clk);
    #2;
  endtask
  task automatic async_reset();
    q.delete();
    trig  = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_pulse_out", pulse_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pend_cnt", pend_cnt, 0);
    chk("rst_ovf_tick", ovf_tick, 0);
    start = -1000;
    pend  = 0;
    ovf   = 1'b0;
    repeat (3) begin
      cyc++;
      q.push_back(expect_now());
      @(posedge clk);
      #2;
    end
    rst_n = 1'b1;
  endtask
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("pulse_out", pulse_out, x.p);
        chk("busy", busy, x.b);
        chk("pend_cnt", pend_cnt, x.c);
        chk("ovf_tick", ovf_tick, x.o);
      end
    end
  end
  initial begin : stim
    int dens;
    repeat (3) @(posedge clk);
    #2;
    chk("init_pulse_out", pulse_out, 0);
    chk("init_busy", busy, 0);
    chk("init_pend_cnt", pend_cnt, 0);
    chk("init_ovf_tick", ovf_tick, 0);
    rst_n = 1'b1;
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (12) step(1'b0);
    step(1'b1);
    step(1'b0);
    step(1'b1);
    repeat (12) step(1'b0);
    step(1'b1);
    repeat (5) step(1'b0);
    step(1'b1);
    repeat (10) step(1'b0);
    step(1'b1);
    repeat (6) step(1'b1);
    repeat (30) step(1'b0);
    step(1'b1);
    step(1'b1);
    step(1'b1);
    async_reset();
    repeat (12) step(1'b0);
    for (int b = 0; b < 8; b++) begin
      dens = (b % 4 == 0) ? 5 : (b % 4 == 1) ? 30 : (b % 4 == 2) ? 80 : 50;
      for (int i = 0; i < 200; i++) step($urandom_range(0, 99) < dens);
      if (b == 4) async_reset();
    end
    repeat (20) step(1'b0);
    #5;
    chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
